// File: rtl/rgmii_clk_pkg.sv
// rtl/rgmii_clk_pkg.sv - shared speed encodings, FSM states and helpers for the RGMII clock generator
package rgmii_clk_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Number of bits needed to count 0..value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rgmii_speed_sync.sv
// rtl/rgmii_speed_sync.sv - multi-stage synchroniser for the asynchronous speed request
module rgmii_speed_sync
    import rgmii_clk_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_speed,
    output logic [1:0] o_speed
);

    logic [1:0] r_sync [STAGES];

    // Shift the request through STAGES flops; reset to gigabit so the clock starts in bypass.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= SPD_1000;
            end
        end else begin
            r_sync[0] <= i_speed;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // 2'b11 is treated as gigabit so downstream logic only ever sees three encodings.
    assign o_speed = r_sync[STAGES-1][1] ? SPD_1000 : r_sync[STAGES-1];

endmodule

// File: rtl/rgmii_clk_gen.sv
// rtl/rgmii_clk_gen.sv - glitch-free RGMII MAC clock generator (bypass / divide-by-N)
module rgmii_clk_gen
    import rgmii_clk_pkg::*;
#(
    parameter int DIV_100     = 5,
    parameter int DIV_10      = 50,
    parameter int CNT_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eth_speed,
    output logic       mac_clk,
    output logic       mac_clk_en,
    output logic [1:0] speed_active,
    output logic       switching
);

    localparam int DIV_MAX = (DIV_100 > DIV_10) ? DIV_100 : DIV_10;
    localparam int HOLD_W  = (HOLD_CYCLES < 2) ? 1 : clog2(HOLD_CYCLES);

    localparam logic [CNT_W-1:0]  L100_LAST = CNT_W'(DIV_100 - 1);
    localparam logic [CNT_W-1:0]  L100_HALF = CNT_W'(DIV_100 / 2);
    localparam logic [CNT_W-1:0]  L10_LAST  = CNT_W'(DIV_10 - 1);
    localparam logic [CNT_W-1:0]  L10_HALF  = CNT_W'(DIV_10 / 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    generate
        if (DIV_100 < 2 || DIV_10 < 2 || HOLD_CYCLES < 1 || SYNC_STAGES < 2 ||
            CNT_W < clog2(DIV_MAX)) begin : g_param_err
            $error("rgmii_clk_gen: illegal parameter combination");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_speed_active;
    logic [1:0]        r_spd_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_clk_int;
    logic              r_gate_n;
    logic [1:0]        w_spd_s;
    logic              w_divided;
    logic              w_spd_changed;
    logic              w_div_step;
    logic [CNT_W-1:0]  w_last;
    logic [CNT_W-1:0]  w_half;

    rgmii_speed_sync #(
        .STAGES (SYNC_STAGES)
    ) u_speed_sync (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_speed (eth_speed),
        .o_speed (w_spd_s)
    );

    assign w_divided     = (r_speed_active != SPD_1000);
    assign w_spd_changed = (w_spd_s != r_spd_d);
    assign w_last        = (r_speed_active == SPD_10) ? L10_LAST : L100_LAST;
    assign w_half        = (r_speed_active == SPD_10) ? L10_HALF : L100_HALF;
    // Keep dividing in RUN, and in DRAIN only long enough to finish a high phase already started.
    assign w_div_step    = ((r_state == RUN) && w_divided) || ((r_state == DRAIN) && r_clk_int);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave RUN on any request change, drain until both clock sources are low, then hold.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_spd_s != r_speed_active) w_state_nxt = DRAIN;
            DRAIN:   if (!r_clk_int && !r_gate_n)   w_state_nxt = HOLD;
            HOLD:    if (!w_spd_changed && r_hold_cnt == HOLD_LAST) w_state_nxt = RUN;
            default: w_state_nxt = HOLD;
        endcase
    end

    // Hold counter restarts whenever the request moves; the new speed is latched on leaving HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt     <= '0;
            r_speed_active <= SPD_1000;
            r_spd_d        <= SPD_1000;
        end else begin
            r_spd_d <= w_spd_s;
            if (r_state != HOLD || w_spd_changed) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
                r_hold_cnt     <= '0;
                r_speed_active <= w_spd_s;
            end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Divider: high for the first floor(DIV/2) counts of each period, parked at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_clk_int <= 1'b0;
        end else if (w_div_step) begin
            r_cnt     <= (r_cnt == w_last) ? '0 : r_cnt + CNT_W'(1);
            r_clk_int <= (r_cnt < w_half);
        end else begin
            r_cnt     <= '0;
            r_clk_int <= 1'b0;
        end
    end

    // Bypass gate changes on the falling edge so it only moves while clk is low.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_gate_n <= 1'b0;
        end else begin
            r_gate_n <= (r_state == RUN) && (r_speed_active == SPD_1000);
        end
    end

    assign mac_clk      = (clk & r_gate_n) | r_clk_int;
    assign mac_clk_en   = (r_state == RUN) && (!w_divided || r_cnt == '0);
    assign speed_active = r_speed_active;
    assign switching    = (r_state != RUN);

endmodule

// File: tb/tb_rgmii_clk_gen.sv
// tb/tb_rgmii_clk_gen.sv - scoreboard bench for rgmii_clk_gen mode changes and clock shape
module tb_rgmii_clk_gen;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] eth_speed = 2'b10;
    logic       mac_clk;
    logic       mac_clk_en;
    logic [1:0] speed_active;
    logic       switching;

    rgmii_clk_gen #(
        .DIV_100     (5),
        .DIV_10      (50),
        .CNT_W       (6),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .eth_speed    (eth_speed),
        .mac_clk      (mac_clk),
        .mac_clk_en   (mac_clk_en),
        .speed_active (speed_active),
        .switching    (switching)
    );

    initial forever #HALF clk = ~clk;

    typedef struct {
        logic [1:0] spd;
        int         sw;
        int         hi;
        int         lo;
        int         prev_hi;
        bit         chk_gap;
        int         id;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     ev_id = 0;
    bit     mon_busy = 1'b0;
    bit     sw_seen = 1'b0;
    int     sw_run = 0;
    int     en_total = 0;
    bit     en_last = 1'b0;
    longint t_edge = 0;
    longint last_rise_t = 0;
    longint last_fall_t = 0;
    longint last_high = 0;
    bit     have_edge = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input longint act, input longint req_min);
        checks++;
        if (act < req_min) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, req_min);
        end
    endtask

    task automatic push(input logic [1:0] spd, input int sw, input int hi, input int lo,
                        input int prev_hi, input bit chk_gap);
        exp_t e;
        e.spd = spd; e.sw = sw; e.hi = hi; e.lo = lo;
        e.prev_hi = prev_hi; e.chk_gap = chk_gap; e.id = ev_id;
        ev_id++;
        q.push_back(e);
    endtask

    // Every mac_clk high or low phase must last at least half a clk period.
    initial forever begin
        @(mac_clk);
        if (have_edge) begin
            check_ge("min_pulse_width", $time - t_edge, HALF);
            if (!mac_clk) last_high = $time - t_edge;
        end
        if (mac_clk) last_rise_t = $time;
        else         last_fall_t = $time;
        t_edge    = $time;
        have_edge = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        sw_seen = switching;
        en_last = mac_clk_en;
        if (mac_clk_en) en_total++;
    end

    // sw_run counts clk edges spent outside RUN since the last RUN cycle.
    initial forever begin
        @(posedge clk);
        if (reset)        sw_run = 0;
        else if (sw_seen) sw_run++;
        else              sw_run = 0;
    end

    initial forever begin
        @(posedge reset);
        #1;
        check("reset_mac_clk", mac_clk, 0);
        check("reset_switching", switching, 1);
        check("reset_speed_active", speed_active, 2'b10);
        check("reset_mac_clk_en", mac_clk_en, 0);
    end

    task automatic wait_mac(input bit lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mac_clk == lvl) begin
                ok = 1'b1;
                break;
            end
            #HALF;
        end
    endtask

    task automatic handle();
        exp_t   e;
        bit     ok;
        longint t_f0, t1, t2, t3;
        int     n0;
        mon_busy = 1'b1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_run_entry: speed_active=%b with nothing queued", speed_active);
        end else begin
            e = q.pop_front();
            check($sformatf("ev%0d_speed_active", e.id), speed_active, e.spd);
            check($sformatf("ev%0d_switch_cycles", e.id), sw_run, e.sw);
            if (e.prev_hi != 0) check($sformatf("ev%0d_last_old_high", e.id), last_high, e.prev_hi);
            t_f0 = last_fall_t;
            #1;
            wait_mac(1'b1, ok);
            if (ok) begin
                t1 = last_rise_t;
                n0 = en_total;
                if (e.chk_gap) check_ge($sformatf("ev%0d_low_gap", e.id), t1 - t_f0, 8 * HALF);
                wait_mac(1'b0, ok);
                t2 = last_fall_t;
                if (ok) wait_mac(1'b1, ok);
                t3 = last_rise_t;
            end
            check($sformatf("ev%0d_edges_seen", e.id), ok, 1);
            if (ok) begin
                check($sformatf("ev%0d_high_time", e.id), t2 - t1, e.hi);
                check($sformatf("ev%0d_low_time", e.id), t3 - t2, e.lo);
                check($sformatf("ev%0d_en_per_period", e.id), en_total - n0, 1);
                check($sformatf("ev%0d_en_before_rise", e.id), en_last, 1);
            end
        end
        mon_busy = 1'b0;
    endtask

    // Monitor: each fall of switching is a RUN entry that must match the oldest expectation.
    initial begin
        bit last_sw;
        last_sw = 1'b1;
        forever begin
            @(negedge clk);
            if (last_sw && !switching && !reset) handle();
            last_sw = switching;
        end
    end

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (q.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_completed"}, done, 1);
    endtask

    task automatic wait_en(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mac_clk_en) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_en_seen"}, seen, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected it to finish");
        $fatal(1);
    end

    initial begin
        // Test 1: reset into gigabit bypass.
        #2 reset = 1'b1;
        push(2'b10, 4, HALF, HALF, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_done("t1_reset_gig");

        // Test 2: gig -> 100M: 1 drain + 4 hold edges, 2 high / 3 low.
        @(negedge clk);
        eth_speed = 2'b01;
        push(2'b01, 5, 4 * HALF, 6 * HALF, 0, 1'b1);
        wait_done("t2_to_100");

        // Test 3a: 100M -> 10M aligned to an enable strobe, 25/25 duty.
        wait_en("t3a");
        eth_speed = 2'b00;
        push(2'b00, 5, 50 * HALF, 50 * HALF, 0, 1'b1);
        wait_done("t3a_to_10");

        // Test 3b: 10M -> 100M right as a high phase starts; the full 25-cycle high must finish.
        wait_en("t3b");
        eth_speed = 2'b01;
        push(2'b01, 28, 4 * HALF, 6 * HALF, 50 * HALF, 1'b1);
        wait_done("t3b_mid_high");

        // Test 4: 01 -> 10 -> 01 with the return landing inside HOLD; hold restarts (8 edges).
        wait_en("t4");
        eth_speed = 2'b10;
        repeat (4) @(negedge clk);
        eth_speed = 2'b01;
        push(2'b01, 8, 4 * HALF, 6 * HALF, 0, 1'b1);
        wait_done("t4_hold_restart");

        // Test 5: reach 10M, reset during a high phase with eth_speed=11, recover at gig.
        wait_en("t5a");
        eth_speed = 2'b00;
        push(2'b00, 5, 50 * HALF, 50 * HALF, 0, 1'b1);
        wait_done("t5a_to_10");
        wait_en("t5b");
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        eth_speed = 2'b11;
        push(2'b10, 4, HALF, HALF, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_done("t5_reset_recover");

        repeat (20) @(negedge clk);
        check("queue_empty_at_end", q.size(), 0);
        check("final_speed_active", speed_active, 2'b10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
